pingpong_fmap_buffer: RTL

Parametrised two-bank ping-pong feature-map buffer placed between a producer layer (e.g. conv1) and a consumer layer (e.g. maxpool). The producer writes CH channels per beat sequentially into one bank. At the same time, the consumer reads the other, completed bank by random address. Banks swap under handshake, which replaces the single-bank write-then-read scheme so both layers can overlap.

---
 rtl/pingpong_pkg.sv | 17 +
 rtl/pp_bank_ram.sv | 37 +++
 rtl/pingpong_fmap_buffer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pingpong_pkg.sv
// Shared types and default geometry for the ping-pong feature-map buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pingpong_pkg;

    localparam int CH_DEF    = 64;
    localparam int DW_DEF    = 16;
    localparam int DEPTH_DEF = 12321;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_st_e;

endpackage

// File: rtl/pp_bank_ram.sv
// One feature-map bank: simple dual-port RAM, one write port and one registered read port.
// Latency: read data appears one cycle after re; writes land on the same edge.
// Backpressure: none; the owner gates we/re.
module pp_bank_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage array; contents survive reset, only the bank state is discarded.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; output register clears so rd_data reads zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pingpong_fmap_buffer.sv
// Two-bank ping-pong feature-map buffer: producer fills one bank while consumer reads the other.
// Latency: rd_data one cycle after accepted rd_en; a filled bank reaches the reader one cycle after FULL.
// Backpressure: wr_ready low while the next write bank is still FULL/DRAINING; optional PPBUF_ERR_FLAGS_EN adds err_sticky.
module pingpong_fmap_buffer
    import pingpong_pkg::*;
#(
    parameter int CH    = CH_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW:0]      frame_len,
    input  logic             wr_valid,
    input  logic [CH*DW-1:0] wr_data,
    output logic             wr_ready,
    output logic             wr_frame_done,
    output logic             rd_avail,
    output logic             rd_bank,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [CH*DW-1:0] rd_data,
    output logic             rd_data_valid,
    input  logic             rd_release,
    output logic [AW:0]      rd_frame_len
`ifdef PPBUF_ERR_FLAGS_EN
    ,
    output logic [2:0]       err_sticky
`endif
);

    localparam int W = CH * DW;

    bank_st_e      st_q [2];
    bank_st_e      st_d [2];
    logic [AW:0]   len_q [2];
    logic [W-1:0]  bank_q [2];
    logic          wr_ptr;
    logic          rd_next;
    logic          rd_sel;
    logic          init_done;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   eff_len;
    logic          wr_fire;
    logic          wr_last;
    logic          rd_fire;
    logic          rel_fire;
    logic          promote;

    // The write bank accepts beats while empty or part-filled; the first beat uses the live frame_len.
    assign wr_ready = init_done && (st_q[wr_ptr] == EMPTY || st_q[wr_ptr] == FILLING);
    assign wr_fire  = wr_valid && wr_ready;
    assign eff_len  = (st_q[wr_ptr] == EMPTY) ? frame_len : len_q[wr_ptr];
    assign wr_last  = wr_fire && ({1'b0, wr_addr} == eff_len - (AW+1)'(1));

    // Only one bank is ever DRAINING, and rd_bank always names it.
    assign rd_avail = (st_q[rd_bank] == DRAINING);
    assign rd_fire  = rd_en && rd_avail;
    assign rel_fire = rd_release && rd_avail;
    assign promote  = !rd_avail && (st_q[rd_next] == FULL);
    assign rd_data  = bank_q[rd_sel];

    // Per-bank next state; write, release and promote hit banks in disjoint states so never collide.
    always_comb begin
        st_d = st_q;
        if (wr_fire) begin
            st_d[wr_ptr] = wr_last ? FULL : FILLING;
        end
        if (rel_fire) begin
            st_d[rd_bank] = EMPTY;
        end
        if (promote) begin
            st_d[rd_next] = DRAINING;
        end
    end

    // Bank state registers plus the one-cycle write-enable holdoff after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q[0]   <= EMPTY;
            st_q[1]   <= EMPTY;
            init_done <= 1'b0;
        end else begin
            st_q      <= st_d;
            init_done <= 1'b1;
        end
    end

    // Write pointer, address counter and per-bank frame length latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= 1'b0;
            wr_addr       <= '0;
            wr_frame_done <= 1'b0;
            len_q[0]      <= '0;
            len_q[1]      <= '0;
        end else begin
            wr_frame_done <= wr_last;
            if (wr_fire && st_q[wr_ptr] == EMPTY) begin
                len_q[wr_ptr] <= frame_len;
            end
            if (wr_last) begin
                wr_addr <= '0;
                wr_ptr  <= ~wr_ptr;
            end else if (wr_fire) begin
                wr_addr <= wr_addr + AW'(1);
            end
        end
    end

    // Reader side: strict alternation of banks, length hand-off and read-valid tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_next       <= 1'b0;
            rd_bank       <= 1'b0;
            rd_sel        <= 1'b0;
            rd_frame_len  <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= rd_fire;
            if (rd_fire) begin
                rd_sel <= rd_bank;
            end
            if (promote) begin
                rd_bank      <= rd_next;
                rd_next      <= ~rd_next;
                rd_frame_len <= len_q[rd_next];
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pp_bank_ram #(
            .W     (W),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_ram (
            .clk   (clk),
            .rst   (rst),
            .we    (wr_fire && (wr_ptr == 1'(b))),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (rd_fire && (rd_bank == 1'(b))),
            .raddr (rd_addr),
            .rdata (bank_q[b])
        );
    end

`ifdef PPBUF_ERR_FLAGS_EN
    // Sticky misuse flags; bit0 ignores the frame_done cycle, the normal first stall cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky <= '0;
        end else begin
            err_sticky <= err_sticky | {rd_fire && ({1'b0, rd_addr} >= rd_frame_len),
                                        rd_en && !rd_avail,
                                        wr_valid && !wr_ready && init_done && !wr_frame_done};
        end
    end
`endif

endmodule
